// File: rtl/ecc_io_bridge_if.sv
// Pad-side bus of the ECC operand/result bridge: narrow beat-in and beat-out channels.
// A beat moves on a rising clock edge where its valid and ready are both high; valid/data never wait on ready.
interface ecc_io_bridge_if #(
    parameter int BUS_W = 4
);
    logic             load_i;
    logic [BUS_W-1:0] din_i;
    logic             load_ready_o;
    logic [BUS_W-1:0] dout_o;
    logic             dout_valid_o;
    logic             dout_ready_i;

    modport master (
        output load_i, din_i, dout_ready_i,
        input  load_ready_o, dout_o, dout_valid_o
    );

    modport slave (
        input  load_i, din_i, dout_ready_i,
        output load_ready_o, dout_o, dout_valid_o
    );
endinterface

// File: rtl/ecc_io_bridge.sv
// Loads five WIDTH-bit operands over a BUS_W pad bus, starts the ECC core, streams kPx/kPy back out.
// Optional BUSY watchdog with sticky error_o is enabled by defining ECC_IO_TIMEOUT_EN.
module ecc_io_bridge #(
    parameter int WIDTH       = 16,
    parameter int BUS_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk_p_i,
    input  logic              reset_n_i,
    ecc_io_bridge_if.slave    pad,
    output logic              final_done_o,
    output logic              error_o,
    output logic              core_start_o,
    output logic [WIDTH-1:0]  core_a_o,
    output logic [WIDTH-1:0]  core_prime_o,
    output logic [WIDTH-1:0]  core_px_o,
    output logic [WIDTH-1:0]  core_py_o,
    output logic [WIDTH-1:0]  core_k_o,
    input  logic [WIDTH-1:0]  core_kpx_i,
    input  logic [WIDTH-1:0]  core_kpy_i,
    input  logic              core_done_i,
    output logic [2:0]        dbg_state_o
);
    localparam int B      = WIDTH / BUS_W;
    localparam int N_IN   = 5 * B;
    localparam int N_OUT  = 2 * B;
    localparam int IN_CW  = $clog2(N_IN);
    localparam int OUT_CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(N_IN - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(N_OUT - 1);

    if ((WIDTH % BUS_W) != 0 || WIDTH < BUS_W || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("ecc_io_bridge: illegal WIDTH/BUS_W/TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_BUSY, S_UNLOAD, S_DONE
    } state_t;

    state_t                state_q;
    logic [5*WIDTH-1:0]    ops_q;
    logic [2*WIDTH-1:0]    res_q;
    logic [IN_CW-1:0]      in_cnt_q;
    logic [OUT_CW-1:0]     out_cnt_q;
    logic                  load_ready_q;
    logic                  dout_valid_q;
    logic                  final_done_q;
    logic                  core_start_q;

`ifdef ECC_IO_TIMEOUT_EN
    localparam int TO_CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_CW-1:0] TO_LAST = TO_CW'(TIMEOUT_CYC - 1);
    logic [TO_CW-1:0] busy_cnt_q;
    logic             error_q;
`endif

    always_ff @(posedge clk_p_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            ops_q        <= '0;
            res_q        <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            load_ready_q <= 1'b1;
            dout_valid_q <= 1'b0;
            final_done_q <= 1'b0;
            core_start_q <= 1'b0;
`ifdef ECC_IO_TIMEOUT_EN
            busy_cnt_q   <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            core_start_q <= 1'b0;
            final_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (pad.load_i) begin
                        // Each beat lands directly in its slice so other operands keep last values.
                        ops_q[in_cnt_q*BUS_W +: BUS_W] <= pad.din_i;
`ifdef ECC_IO_TIMEOUT_EN
                        error_q <= 1'b0;
`endif
                        if (in_cnt_q == IN_LAST) begin
                            in_cnt_q     <= '0;
                            load_ready_q <= 1'b0;
                            core_start_q <= 1'b1;
                            state_q      <= S_START;
                        end else begin
                            in_cnt_q <= in_cnt_q + 1'b1;
                            state_q  <= S_LOAD;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_BUSY;
`ifdef ECC_IO_TIMEOUT_EN
                    busy_cnt_q <= '0;
`endif
                end
                S_BUSY: begin
                    if (core_done_i) begin
                        res_q        <= {core_kpy_i, core_kpx_i};
                        dout_valid_q <= 1'b1;
                        state_q      <= S_UNLOAD;
                    end
`ifdef ECC_IO_TIMEOUT_EN
                    else if (busy_cnt_q == TO_LAST) begin
                        final_done_q <= 1'b1;
                        error_q      <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 1'b1;
                    end
`endif
                end
                S_UNLOAD: begin
                    if (pad.dout_ready_i) begin
                        res_q <= res_q >> BUS_W;
                        if (out_cnt_q == OUT_LAST) begin
                            out_cnt_q    <= '0;
                            dout_valid_q <= 1'b0;
                            final_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            out_cnt_q <= out_cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    load_ready_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    load_ready_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign pad.load_ready_o = load_ready_q;
    assign pad.dout_valid_o = dout_valid_q;
    assign pad.dout_o       = res_q[BUS_W-1:0];
    assign final_done_o     = final_done_q;
    assign core_start_o     = core_start_q;
    assign core_a_o         = ops_q[0*WIDTH +: WIDTH];
    assign core_prime_o     = ops_q[1*WIDTH +: WIDTH];
    assign core_px_o        = ops_q[2*WIDTH +: WIDTH];
    assign core_py_o        = ops_q[3*WIDTH +: WIDTH];
    assign core_k_o         = ops_q[4*WIDTH +: WIDTH];
    assign dbg_state_o      = state_q;

`ifdef ECC_IO_TIMEOUT_EN
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_ecc_io_bridge.sv
// Directed bench for ecc_io_bridge: curve y^2 = x^3 + 2x + 2 mod 17, 2*(5,1) = (6,3).
// Build with ECC_IO_TIMEOUT_EN to exercise the watchdog instead of the long core latency.
module tb_ecc_io_bridge;
    localparam int WIDTH       = 8;
    localparam int BUS_W       = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int N_IN        = 10;

    logic             clk;
    logic             reset_n;
    logic             final_done;
    logic             error;
    logic             core_start;
    logic [WIDTH-1:0] core_a, core_prime, core_px, core_py, core_k;
    logic [WIDTH-1:0] core_kpx, core_kpy;
    logic             core_done;
    logic [2:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [BUS_W-1:0] exp_q[$];
    logic [BUS_W-1:0] beats[N_IN];

    ecc_io_bridge_if #(.BUS_W(BUS_W)) pad_if ();

    ecc_io_bridge #(
        .WIDTH(WIDTH), .BUS_W(BUS_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_p_i      (clk),
        .reset_n_i    (reset_n),
        .pad          (pad_if),
        .final_done_o (final_done),
        .error_o      (error),
        .core_start_o (core_start),
        .core_a_o     (core_a),
        .core_prime_o (core_prime),
        .core_px_o    (core_px),
        .core_py_o    (core_py),
        .core_k_o     (core_k),
        .core_kpx_i   (core_kpx),
        .core_kpy_i   (core_kpy),
        .core_done_i  (core_done),
        .dbg_state_o  (dbg_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // behavioural core: k*P by repeated affine addition
    function automatic int md(input int v, input int p);
        int r;
        r = v % p;
        if (r < 0) r += p;
        return r;
    endfunction

    function automatic int minv(input int v, input int p);
        for (int i = 1; i < p; i++)
            if (md(v * i, p) == 1) return i;
        return 0;
    endfunction

    function automatic void ec_mul(input int k, input int p, input int a, input int px,
                                   input int py, output int rx, output int ry);
        int lam, nx, ny;
        rx = px;
        ry = py;
        for (int i = 1; i < k; i++) begin
            if (rx == px && ry == py)
                lam = md((3 * px * px + a) * minv(md(2 * py, p), p), p);
            else
                lam = md((ry - py) * minv(md(rx - px, p), p), p);
            nx = md(lam * lam - rx - px, p);
            ny = md(lam * (rx - nx) - ry, p);
            rx = nx;
            ry = ny;
        end
    endfunction

    // driver tasks
    task automatic expect_result();
        exp_q.delete();
        exp_q.push_back(4'h6);
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h3);
        exp_q.push_back(4'h0);
    endtask

    task automatic drive_beats(input int n, input bit gaps, input bit done_noise);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 1)) begin
                pad_if.load_i = 1'b0;
                tick();
            end
            pad_if.load_i = 1'b1;
            pad_if.din_i  = beats[i];
            if (done_noise) begin
                core_done = 1'b1;
                core_kpx  = 8'hFF;
                core_kpy  = 8'hFF;
            end
            tick();
        end
        pad_if.load_i = 1'b0;
    endtask

    task automatic check_start();
        check("start_pulse", core_start, 1);
        check("load_ready_low", pad_if.load_ready_o, 0);
        check("op_a", core_a, 8'd2);
        check("op_prime", core_prime, 8'd17);
        check("op_px", core_px, 8'd5);
        check("op_py", core_py, 8'd1);
        check("op_k", core_k, 8'd2);
    endtask

    task automatic core_finish(input int delay);
        int rx, ry;
        repeat (delay) tick();
        check("no_early_valid", pad_if.dout_valid_o, 0);
        check("no_error", error, 0);
        ec_mul(int'(core_k), int'(core_prime), int'(core_a), int'(core_px), int'(core_py), rx, ry);
        core_kpx  = WIDTH'(rx);
        core_kpy  = WIDTH'(ry);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_kpx  = 8'hEE;
        core_kpy  = 8'hEE;
        check("valid_after_done", pad_if.dout_valid_o, 1);
    endtask

    task automatic unload(input int max_beats, input bit toggle);
        int got;
        bit phase;
        got   = 0;
        phase = 1'b0;
        for (int c = 0; c < 64 && got < max_beats; c++) begin
            check("dout_valid", pad_if.dout_valid_o, 1);
            check("dout_beat", pad_if.dout_o, exp_q[0]);
            pad_if.dout_ready_i = toggle ? phase : 1'b1;
            phase = ~phase;
            if (pad_if.dout_ready_i) begin
                void'(exp_q.pop_front());
                got++;
            end
            tick();
        end
        pad_if.dout_ready_i = 1'b0;
        check("unload_count", got, max_beats);
    endtask

    task automatic finish_checks();
        check("final_done", final_done, 1);
        check("valid_off", pad_if.dout_valid_o, 0);
        check("ready_in_done", pad_if.load_ready_o, 0);
        tick();
        check("final_done_once", final_done, 0);
        check("ready_again", pad_if.load_ready_o, 1);
        check("queue_empty", exp_q.size(), 0);
        check("ops_held_a", core_a, 8'd2);
        check("ops_held_k", core_k, 8'd2);
    endtask

    task automatic full_txn(input bit gaps, input bit toggle, input int delay);
        expect_result();
        drive_beats(N_IN, gaps, 1'b0);
        check_start();
        tick();
        check("start_single", core_start, 0);
        core_finish(delay);
        unload(4, toggle);
        finish_checks();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, pad_if.load_ready_o, 1);
        check({tag, "_valid"}, pad_if.dout_valid_o, 0);
        check({tag, "_dout"}, pad_if.dout_o, 0);
        check({tag, "_final"}, final_done, 0);
        check({tag, "_start"}, core_start, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_a"}, core_a, 0);
        check({tag, "_prime"}, core_prime, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        beats = '{4'h2, 4'h0, 4'h1, 4'h1, 4'h5, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
        reset_n             = 1'b0;
        pad_if.load_i       = 1'b0;
        pad_if.din_i        = '0;
        pad_if.dout_ready_i = 1'b0;
        core_done           = 1'b0;
        core_kpx            = '0;
        core_kpy            = '0;
        repeat (2) tick();
        check_reset_state("por");
        reset_n = 1'b1;
        tick();

        // back-to-back transaction, immediate core
        full_txn(1'b0, 1'b0, 1);

        // load gaps and output stalls
        full_txn(1'b1, 1'b1, 3);

        // reset after beat 5
        drive_beats(5, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        check_reset_state("rst_load");
        reset_n = 1'b1;
        tick();
        full_txn(1'b0, 1'b0, 2);

        // reset during unload after two beats
        expect_result();
        drive_beats(N_IN, 1'b0, 1'b0);
        check_start();
        core_finish(2);
        unload(2, 1'b0);
        check("mid_unload_beat", pad_if.dout_o, 4'h3);
        reset_n = 1'b0;
        tick();
        check_reset_state("rst_unload");
        exp_q.delete();
        reset_n = 1'b1;
        tick();
        full_txn(1'b1, 1'b0, 1);

        // core_done during LOAD and START must be ignored
        expect_result();
        drive_beats(N_IN, 1'b0, 1'b1);
        check_start();
        tick();
        core_done = 1'b0;
        check("done_in_load_start_ignored", pad_if.dout_valid_o, 0);
        check("busy_state", dbg_state, 3);
        tick();
        check("still_no_valid", pad_if.dout_valid_o, 0);
        core_finish(2);
        unload(4, 1'b0);
        finish_checks();

`ifdef ECC_IO_TIMEOUT_EN
        begin
            int cyc;
            bit seen;
            drive_beats(N_IN, 1'b0, 1'b0);
            check_start();
            cyc  = 0;
            seen = 1'b0;
            while (cyc < 40 && !seen) begin
                tick();
                cyc++;
                check("timeout_no_valid", pad_if.dout_valid_o, 0);
                if (final_done) seen = 1'b1;
            end
            check("timeout_cycles", cyc, 17);
            check("timeout_error", error, 1);
            tick();
            check("error_sticky", error, 1);
            check("timeout_ready", pad_if.load_ready_o, 1);
            drive_beats(1, 1'b0, 1'b0);
            check("error_cleared", error, 0);
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            tick();
            full_txn(1'b0, 1'b0, 5);
        end
`else
        full_txn(1'b0, 1'b1, 10000);
        check("long_wait_error", error, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
